fft_result_streamer: RTL
========================

# fft_result_streamer

Output-side companion to the 16-point FFT core. On a start pulse it waits the core's fixed pipeline latency, snapshots all N parallel complex bins into an internal buffer, and streams them one bin per transfer over a valid/ready interface. It optionally reorders bins and applies an arithmetic right-shift scale. This turns the core's wide parallel result into a serial stream for downstream logic.

## Interface
- DATA_W, 16: width of each real/imag component, signed two's complement (Q8.8, 256 = 1.0)
- N, 16: number of bins; power of two, 2..16
- LATENCY, 4: clock edges from start sample to valid core outputs; must be 1..15
- BIT_REVERSE, 0: 1 = streamed bin k is read from buffer slot bitrev(k) over log2(N) bits
- SHIFT, 0: arithmetic right shift applied to both components on output; 0..DATA_W-1
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: core inputs are applied this cycle
- in_re  input  N*DATA_W  core real outputs; bin k at [k*DATA_W +: DATA_W]
- in_im  input  N*DATA_W  core imaginary outputs, same packing
- out_valid  output  1  out_re/out_im/out_index/out_last hold a bin
- out_ready  input  1  downstream accepts; transfer = out_valid & out_ready
- out_re  output  DATA_W  scaled real part of current bin
- out_im  output  DATA_W  scaled imaginary part of current bin
- out_index  output  log2(N)  natural bin number 0..N-1
- out_last  output  1  high with out_valid on bin N-1
- busy  output  1  state is not IDLE
- overrun  output  1  one-cycle pulse: a start was dropped

## Operation
- States: IDLE, WAIT, STREAM.
- IDLE:
  - start=1 loads the wait counter with LATENCY-1 and moves to WAIT.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter is 0, the buffer captures in_re/in_im, index clears to 0, and the state moves to STREAM.
  - This is the LATENCY-th edge after the start edge.
- STREAM:
  - out_valid=1.
  - On each transfer, index increments.
  - A transfer with index=N-1 ends the frame: go to IDLE, or to WAIT if start=1 in that same cycle (back-to-back accepted, no overrun).
- Dropped starts: start=1 in WAIT, or in STREAM outside the final-transfer cycle, is ignored and overrun pulses high the next cycle. The buffer is never overwritten mid-frame.
- Read slot = BIT_REVERSE ? bitrev(index) : index. out_index always reports the natural index.
- Scaling: out_re = buf_re[slot] >>> SHIFT, sign-extended, truncated toward negative infinity. Same rule for out_im. No rounding and no saturation (shift cannot overflow).
- Stall: while out_valid=1 and out_ready=0, all out_* hold stable.
- out_last = out_valid & (index == N-1).
- Reset (asynchronous, any state, including mid-WAIT and mid-STREAM):
  - state IDLE, counter 0, index 0, buffer all zero.
  - out_valid 0, out_last 0, busy 0, overrun 0, out_re 0, out_im 0, out_index 0.
  - A partially streamed frame is discarded.

## Timing
- Start sampled at edge E0; capture at edge E0+LATENCY; out_valid rises after that edge.
- First bin is offered LATENCY cycles after the start cycle.
- With out_ready held high, bins 0..N-1 transfer on N consecutive edges.
- Minimum start-to-start spacing with no stalls: LATENCY+N cycles, achieved by pulsing start in the final-transfer cycle.
- busy rises the cycle after start is accepted and falls the cycle after the final transfer, unless a back-to-back start was accepted.
- in_re/in_im need only be valid in the capture cycle.
- out_* come from registered state through a read mux; there is no combinational path from out_ready to out_valid.

## Test plan
- Nominal frame (defaults): drive in_re/in_im with the FFT of x0=256, x1=512 (bin0=768+0j, bin4=256-512j, bin8=-256+0j, bin12=256+512j), pulse start, hold out_ready=1.
  - out_valid rises 4 cycles after start.
  - 16 consecutive bins appear with correct values; out_last only on index 15; busy falls afterwards.
- Backpressure: same data, out_ready toggled pseudo-randomly.
  - No bin lost or duplicated; outputs stable during stalls; index order 0..15.
- Bit reverse and scale (BIT_REVERSE=1, SHIFT=2): in_re slot s = s*64, in_im = -s*64.
  - index 1 yields slot 8: out_re=128, out_im=-128.
  - index 3 yields slot 12: out_re=192, out_im=-192.
- Overrun: start during WAIT and again mid-STREAM.
  - overrun pulses once each; the frame is unchanged.
  - start in the final-transfer cycle is accepted: busy stays high and the next frame's out_valid rises 4 cycles later.
- Reset mid-operation: assert rst asynchronously during WAIT and again at index 7 of STREAM.
  - All outputs go to zero immediately; next start behaves as a fresh frame.
- Negative scaling: in_re bin0 = -3, SHIFT=1.
  - out_re = -2 (floor), not -1.

Source files
------------

// File: rtl/fft_result_streamer.sv
// Snapshots the FFT core's parallel bins after its pipeline latency and streams
// them one bin per valid/ready transfer, with optional bit-reversed reads and scaling.
module fft_result_streamer #(
   parameter int DATA_W      = 16,
   parameter int N           = 16,
   parameter int LATENCY     = 4,
   parameter int BIT_REVERSE = 0,
   parameter int SHIFT       = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [N*DATA_W-1:0]    in_re,
   input  logic [N*DATA_W-1:0]    in_im,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_re,
   output logic [DATA_W-1:0]      out_im,
   output logic [$clog2(N)-1:0]   out_index,
   output logic                   out_last,
   output logic                   busy,
   output logic                   overrun
);

   localparam int IW = $clog2(N);
   localparam int CW = 4;
   localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
   localparam logic [CW-1:0] CNT_START = CW'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

   state_t                   state, state_n;
   logic [CW-1:0]            cnt, cnt_n;
   logic [IW-1:0]            idx, idx_n;
   logic                     capture;
   logic                     drop;
   logic                     xfer;
   logic                     final_xfer;
   logic signed [DATA_W-1:0] buf_re [N];
   logic signed [DATA_W-1:0] buf_im [N];
   logic [IW-1:0]            slot;
   logic signed [DATA_W-1:0] sel_re, sel_im;

   function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
      logic [IW-1:0] r;
      r = '0;
      for (int i = 0; i < IW; i++) r[i] = v[IW-1-i];
      return r;
   endfunction

   assign xfer       = (state == STREAM) && out_ready;
   assign final_xfer = xfer && (idx == LAST_IDX);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      capture = 1'b0;
      drop    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = WAIT;
               cnt_n   = CNT_START;
            end
         end
         WAIT: begin
            drop = start;
            if (cnt == '0) begin
               capture = 1'b1;
               idx_n   = '0;
               state_n = STREAM;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         STREAM: begin
            if (xfer) idx_n = idx + IW'(1);
            // A start coinciding with the last transfer chains the next frame.
            if (final_xfer) begin
               if (start) begin
                  state_n = WAIT;
                  cnt_n   = CNT_START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               drop = start;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         overrun <= 1'b0;
         for (int k = 0; k < N; k++) begin
            buf_re[k] <= '0;
            buf_im[k] <= '0;
         end
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         overrun <= drop;
         if (capture) begin
            for (int k = 0; k < N; k++) begin
               buf_re[k] <= in_re[k*DATA_W +: DATA_W];
               buf_im[k] <= in_im[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   // out_index stays natural; only the buffer read slot is permuted.
   assign slot      = (BIT_REVERSE != 0) ? bitrev(idx) : idx;
   assign sel_re    = buf_re[slot];
   assign sel_im    = buf_im[slot];
   assign out_re    = sel_re >>> SHIFT;
   assign out_im    = sel_im >>> SHIFT;
   assign out_valid = (state == STREAM);
   assign out_index = idx;
   assign out_last  = out_valid && (idx == LAST_IDX);
   assign busy      = (state != IDLE);

endmodule
